// File: rtl/btn_db_repeat.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce FSM, press/release ticks and long-press auto-repeat.
// Define BTN_REPEAT_EN to build the hold/repeat logic (REPEAT state, hcnt, rpt_tick, long_press).
module btn_db_repeat #(
  parameter int DB_CNT   = 2_000_000,
  parameter int HOLD_CNT = 50_000_000,
  parameter int RPT_CNT  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic rpt_tick,
  output logic long_press
);

  localparam int DW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DB_CNT - 1);

  if (DB_CNT < 1 || HOLD_CNT < 1 || RPT_CNT < 1) begin : g_param_chk
    $error("btn_db_repeat: DB_CNT, HOLD_CNT and RPT_CNT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, WAIT1, PRESSED, REPEAT, WAIT0} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic            sw_p0, sw_s;
  logic            db_nxt, rise_nxt, fall_nxt;

`ifdef BTN_REPEAT_EN
  localparam int HMAX = (HOLD_CNT > RPT_CNT) ? HOLD_CNT : RPT_CNT;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CNT - 1);
  localparam logic [HW-1:0] R_LAST = HW'(RPT_CNT - 1);

  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic            rpt_nxt, lp_nxt;
`else
  assign rpt_tick   = 1'b0;
  assign long_press = 1'b0;
`endif

  // Stage p0/p1: two-flop synchronizer; only sw_s reaches the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_p0 <= 1'b0;
      sw_s  <= 1'b0;
    end else begin
      sw_p0 <= sw;
      sw_s  <= sw_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
`ifdef BTN_REPEAT_EN
    hcnt_nxt  = hcnt;
    rpt_nxt   = 1'b0;
    lp_nxt    = long_press;
`endif
    case (state)
      IDLE: begin
        if (sw_s) begin
          state_nxt = WAIT1;
          dcnt_nxt  = '0;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_nxt = IDLE;
        end else if (dcnt == D_LAST) begin
          state_nxt = PRESSED;
          rise_nxt  = 1'b1;
`ifdef BTN_REPEAT_EN
          hcnt_nxt  = '0;
`endif
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        // Release beats a coinciding hold terminal count; hcnt stays frozen across WAIT0
        if (!sw_s) begin
          state_nxt = WAIT0;
          dcnt_nxt  = '0;
        end
`ifdef BTN_REPEAT_EN
        else if (hcnt == H_LAST) begin
          state_nxt = REPEAT;
          hcnt_nxt  = '0;
          lp_nxt    = 1'b1;
          rpt_nxt   = 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
`endif
      end
`ifdef BTN_REPEAT_EN
      REPEAT: begin
        if (!sw_s) begin
          state_nxt = WAIT0;
          dcnt_nxt  = '0;
        end else if (hcnt == R_LAST) begin
          hcnt_nxt = '0;
          rpt_nxt  = 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
`endif
      WAIT0: begin
        if (sw_s) begin
`ifdef BTN_REPEAT_EN
          // long_press doubles as the record of which hold state was left
          state_nxt = long_press ? REPEAT : PRESSED;
`else
          state_nxt = PRESSED;
`endif
        end else if (dcnt == D_LAST) begin
          state_nxt = IDLE;
          fall_nxt  = 1'b1;
`ifdef BTN_REPEAT_EN
          lp_nxt    = 1'b0;
`endif
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    db_nxt = (state_nxt == PRESSED) || (state_nxt == REPEAT) || (state_nxt == WAIT0);
  end

  // Stage p2: FSM state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dcnt       <= '0;
      db_level   <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
`ifdef BTN_REPEAT_EN
      hcnt       <= '0;
      rpt_tick   <= 1'b0;
      long_press <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      dcnt       <= dcnt_nxt;
      db_level   <= db_nxt;
      rise_tick  <= rise_nxt;
      fall_tick  <= fall_nxt;
`ifdef BTN_REPEAT_EN
      hcnt       <= hcnt_nxt;
      rpt_tick   <= rpt_nxt;
      long_press <= lp_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_btn_db_repeat.sv
// Randomized bench for btn_db_repeat against a run-length reference model (DB_CNT=4, HOLD_CNT=10, RPT_CNT=3).
// Honors BTN_REPEAT_EN the same way as the design.
module tb_btn_db_repeat;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int RPT  = 3;

  logic clk, reset, sw;
  logic db_level, rise_tick, fall_tick, rpt_tick, long_press;

  btn_db_repeat #(.DB_CNT(DB), .HOLD_CNT(HOLD), .RPT_CNT(RPT)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .db_level(db_level), .rise_tick(rise_tick), .fall_tick(fall_tick),
    .rpt_tick(rpt_tick), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: debounce is "sw_s has disagreed with the level for DB+1 samples";
  // hold time is the count of agreeing samples since the press, excluding glitch periods.
  logic m_s1, m_s2, m_db, m_lp, m_rise, m_fall, m_rpt;
  int   m_pend, m_held;

  int edge_n, first_rise, first_fall, first_lp, n_rise, n_fall, n_rpt;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_lp = 0;
    m_rise = 0; m_fall = 0; m_rpt = 0;
    m_pend = 0; m_held = 0;
  endtask

  task automatic model_step(input logic s);
    logic ss;
    ss = m_s2;
    m_s2 = m_s1;
    m_s1 = s;
    m_rise = 0; m_fall = 0; m_rpt = 0;
    if (!m_db) begin
      if (ss) begin
        m_pend++;
        if (m_pend == DB + 1) begin
          m_db = 1; m_pend = 0; m_held = 0; m_rise = 1;
        end
      end else begin
        m_pend = 0;
      end
    end else begin
      if (!ss) begin
        m_pend++;
        if (m_pend == DB + 1) begin
          m_db = 0; m_pend = 0; m_fall = 1; m_lp = 0;
        end
      end else if (m_pend > 0) begin
        m_pend = 0;
      end else begin
`ifdef BTN_REPEAT_EN
        m_held++;
        if (m_held == HOLD || (m_held > HOLD && (m_held - HOLD) % RPT == 0)) begin
          m_rpt = 1;
          m_lp  = 1;
        end
`endif
      end
    end
  endtask

  task automatic mark();
    edge_n = 0; first_rise = 0; first_fall = 0; first_lp = 0;
    n_rise = 0; n_fall = 0; n_rpt = 0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "db_level"},   int'(db_level),   int'(m_db));
    chk({pfx, "rise_tick"},  int'(rise_tick),  int'(m_rise));
    chk({pfx, "fall_tick"},  int'(fall_tick),  int'(m_fall));
    chk({pfx, "rpt_tick"},   int'(rpt_tick),   int'(m_rpt));
    chk({pfx, "long_press"}, int'(long_press), int'(m_lp));
  endtask

  // One clock: drive sw, advance model on the edge, compare on the falling edge
  task automatic cyc(input logic s);
    sw = s;
    @(posedge clk);
    edge_n++;
    if (reset) model_reset();
    else model_step(s);
    @(negedge clk);
    check_outputs("");
    if (rise_tick) begin n_rise++; if (first_rise == 0) first_rise = edge_n; end
    if (fall_tick) begin n_fall++; if (first_fall == 0) first_fall = edge_n; end
    if (rpt_tick)  n_rpt++;
    if (long_press && first_lp == 0) first_lp = edge_n;
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_");
    @(negedge clk);
    cyc(1'b1);
    cyc(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw    = 1'b0;
    model_reset();
    mark();
    #1;
    check_outputs("por_");
    repeat (3) cyc(1'b0);
    reset = 1'b0;
    repeat (4) cyc(1'b0);

    // Clean press then release
    mark();
    repeat (12) cyc(1'b1);
    chk("clean_rise_edge", first_rise, 7);
    chk("clean_rise_count", n_rise, 1);
    chk("clean_no_lp", first_lp, 0);
    repeat (12) cyc(1'b0);
    chk("clean_fall_count", n_fall, 1);

    // Bounce shorter than the debounce window
    mark();
    repeat (5) begin
      repeat (3) cyc(1'b1);
      repeat (2) cyc(1'b0);
    end
    repeat (6) cyc(1'b0);
    chk("bounce_rise", n_rise, 0);
    chk("bounce_fall", n_fall, 0);

    // Long hold, release glitch, clean release
    mark();
    repeat (30) cyc(1'b1);
    chk("hold_rise_edge", first_rise, 7);
`ifdef BTN_REPEAT_EN
    chk("hold_lp_edge", first_lp, 17);
    chk("hold_rpt_count", n_rpt, 5);
`else
    chk("hold_rpt_count", n_rpt, 0);
    chk("hold_lp_edge", first_lp, 0);
`endif
    mark();
    repeat (2) cyc(1'b0);
    repeat (12) cyc(1'b1);
    chk("glitch_fall", n_fall, 0);
    mark();
    repeat (12) cyc(1'b0);
    chk("release_fall_edge", first_fall, 7);
    chk("release_fall_count", n_fall, 1);

    // Reset asserted in WAIT1 and in a long hold
    repeat (4) cyc(1'b1);
    mid_reset();
    repeat (6) cyc(1'b0);
    repeat (25) cyc(1'b1);
    mid_reset();
    repeat (8) cyc(1'b0);

    // Random segments mixing bounces, presses, long holds and glitches
    for (int seg = 0; seg < 120; seg++) begin
      logic lvl;
      int   len;
      lvl = seg[0];
      case ($urandom_range(0, 3))
        0: len = $urandom_range(1, 4);
        1: len = $urandom_range(5, 10);
        2: len = $urandom_range(11, 40);
        default: len = $urandom_range(1, 2);
      endcase
      for (int i = 0; i < len; i++) cyc(lvl);
      if ($urandom_range(0, 24) == 0) mid_reset();
    end
    repeat (10) cyc(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
